// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator.
package fetch_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JUMP = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } br_kind_e;

   localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: oldest entry is overwritten when full, count saturates at DEPTH.
module ras_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [XLEN-1:0]          push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic [XLEN-1:0]          top,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en;

   // ptr_q names the next free slot; the top lives one below it.
   assign top_idx = ptr_q - PTR_W'(1);
   assign top     = mem_q[top_idx];
   assign count   = count_q;

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      if (clear) begin
         ptr_d   = '0;
         count_d = '0;
         if (push) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            ptr_d   = PTR_W'(1);
            count_d = CNT_W'(1);
         end
      end else if (push && pop) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push) begin
         wr_en   = 1'b1;
         ptr_d   = ptr_q + PTR_W'(1);
         count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
      end else if (pop && count_q != '0) begin
         ptr_d   = top_idx;
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= push_data;
   end

endmodule

// File: rtl/fetch_ras.sv
// Fetch PC generator: redirect > stall hold > RAS > BTB > pc+4, with decode handshake.
module fetch_ras
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     RAS_DEPTH    = 8,
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_valid,
   input  logic             upd_taken,
   input  logic             upd_mispredicted,
   input  logic [1:0]       upd_kind,
   input  logic [XLEN-1:0]  upd_addr,
   input  logic [XLEN-1:0]  upd_target,
   input  logic             pred_hit,
   input  logic             pred_taken,
   input  logic [1:0]       pred_kind,
   input  logic [XLEN-1:0]  pred_target,
   input  logic             fetch_ready,
   output logic [XLEN-1:0]  query_pc,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  next_pc,
   output logic             fetch_valid,
   output logic [CNT_W-1:0] redirect_count
);

   localparam int unsigned RC_W = $clog2(RAS_DEPTH) + 1;

   logic             upd_valid_q, upd_taken_q, upd_mispredicted_q;
   logic [1:0]       upd_kind_q;
   logic [XLEN-1:0]  upd_addr_q, upd_target_q;
   logic [XLEN-1:0]  pc_q, pc_plus4;
   logic             fetch_valid_q;
   logic [CNT_W-1:0] redirect_count_q;

   logic             redirect, fire, hit_ret, hit_call, ras_nonempty;
   logic             ras_push, ras_pop;
   logic [XLEN-1:0]  ras_push_data, ras_top;
   logic [RC_W-1:0]  ras_count;

   assign redirect     = upd_valid_q & upd_mispredicted_q;
   assign fire         = fetch_valid_q & fetch_ready;
   assign pc_plus4     = pc_q + XLEN'(INSN_BYTES);
   assign ras_nonempty = (ras_count != '0);
   assign hit_ret      = pred_hit & (pred_kind == BR_RET);
   assign hit_call     = pred_hit & (pred_kind == BR_CALL);

   always_comb begin
      next_pc = pc_plus4;
      if (redirect) begin
         next_pc = upd_target_q;
      end else if (!fire) begin
         next_pc = pc_q;
      end else if (hit_ret && ras_nonempty) begin
         next_pc = ras_top;
      end else if (pred_hit && (pred_kind != BR_COND || pred_taken)) begin
         next_pc = pred_target;
      end
   end

   // A redirect repairs the RAS from the resolved branch instead of speculating.
   always_comb begin
      ras_push      = 1'b0;
      ras_pop       = 1'b0;
      ras_push_data = pc_plus4;
      if (redirect) begin
         ras_push      = (upd_kind_q == BR_CALL);
         ras_push_data = upd_addr_q + XLEN'(INSN_BYTES);
      end else if (fire) begin
         ras_push = hit_call;
         ras_pop  = hit_ret & ras_nonempty;
      end
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .XLEN  (XLEN)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .push_data (ras_push_data),
      .pop       (ras_pop),
      .clear     (redirect),
      .top       (ras_top),
      .count     (ras_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_valid_q        <= 1'b0;
         upd_taken_q        <= 1'b0;
         upd_mispredicted_q <= 1'b0;
         upd_kind_q         <= '0;
         upd_addr_q         <= '0;
         upd_target_q       <= '0;
      end else begin
         upd_valid_q        <= upd_valid;
         upd_taken_q        <= upd_taken;
         upd_mispredicted_q <= upd_mispredicted;
         upd_kind_q         <= upd_kind;
         upd_addr_q         <= upd_addr;
         upd_target_q       <= upd_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q             <= RESET_VECTOR;
         fetch_valid_q    <= 1'b0;
         redirect_count_q <= '0;
      end else begin
         pc_q          <= next_pc;
         fetch_valid_q <= 1'b1;
         if (redirect && redirect_count_q != '1) begin
            redirect_count_q <= redirect_count_q + CNT_W'(1);
         end
      end
   end

   assign query_pc       = next_pc;
   assign pc             = pc_q;
   assign fetch_valid    = fetch_valid_q;
   assign redirect_count = redirect_count_q;

   logic unused_taken;
   assign unused_taken = upd_taken_q;

endmodule

// File: tb/tb_fetch_ras.sv
// Directed plus random checks of fetch_ras against a queue-based reference model.
module tb_fetch_ras;
   import fetch_pkg::*;

   localparam int unsigned XL  = 32;
   localparam logic [31:0] RV  = 32'h100;
   localparam int unsigned DEP = 8;
   localparam int unsigned CW  = 2;

   localparam logic [1:0] KCOND = 2'd0;
   localparam logic [1:0] KJUMP = 2'd1;
   localparam logic [1:0] KCALL = 2'd2;
   localparam logic [1:0] KRET  = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredicted = 1'b0;
   logic [1:0]    upd_kind = '0;
   logic [31:0]   upd_addr = '0, upd_target = '0;
   logic          pred_hit = 1'b0, pred_taken = 1'b0;
   logic [1:0]    pred_kind = '0;
   logic [31:0]   pred_target = '0;
   logic          fetch_ready = 1'b0;
   logic [31:0]   query_pc, pc, next_pc;
   logic          fetch_valid;
   logic [CW-1:0] redirect_count;

   fetch_ras #(
      .XLEN         (XL),
      .RESET_VECTOR (RV),
      .RAS_DEPTH    (DEP),
      .CNT_W        (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .upd_valid        (upd_valid),
      .upd_taken        (upd_taken),
      .upd_mispredicted (upd_mispredicted),
      .upd_kind         (upd_kind),
      .upd_addr         (upd_addr),
      .upd_target       (upd_target),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_kind        (pred_kind),
      .pred_target      (pred_target),
      .fetch_ready      (fetch_ready),
      .query_pc         (query_pc),
      .pc               (pc),
      .next_pc          (next_pc),
      .fetch_valid      (fetch_valid),
      .redirect_count   (redirect_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic        m_valid;
   int          m_cnt;
   logic [31:0] m_ras[$];
   logic        m_uv, m_um;
   logic [1:0]  m_uk;
   logic [31:0] m_ua, m_ut;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RV; m_valid = 1'b0; m_cnt = 0; m_ras.delete();
      m_uv = 1'b0; m_um = 1'b0; m_uk = '0; m_ua = '0; m_ut = '0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".pc"}, 64'(pc), 64'(m_pc));
      check({tag, ".valid"}, 64'(fetch_valid), 64'(m_valid));
      check({tag, ".rcnt"}, 64'(redirect_count), 64'(m_cnt));
      check({tag, ".rasn"}, 64'(dut.u_ras.count), 64'(m_ras.size()));
   endtask

   task automatic ras_push(input logic [31:0] a);
      m_ras.push_back(a);
      if (m_ras.size() > DEP) void'(m_ras.pop_front());
   endtask

   // One clock: drive inputs, check next_pc, advance model, check registered state.
   task automatic step(input logic rdy, input logic hit, input logic tk, input logic [1:0] kd,
                       input logic [31:0] tgt, input logic uv, input logic um,
                       input logic [1:0] uk, input logic [31:0] ua, input logic [31:0] ut);
      logic        redir, fire;
      logic [31:0] exp_next;
      fetch_ready = rdy; pred_hit = hit; pred_taken = tk; pred_kind = kd; pred_target = tgt;
      upd_valid = uv; upd_mispredicted = um; upd_taken = um ^ tk; upd_kind = uk;
      upd_addr = ua; upd_target = ut;
      #1;
      redir = m_uv & m_um;
      fire  = m_valid & rdy;
      if (redir)                                     exp_next = m_ut;
      else if (!fire)                                exp_next = m_pc;
      else if (hit && kd == KRET && m_ras.size() > 0) exp_next = m_ras[$];
      else if (hit && (kd != KCOND || tk))           exp_next = tgt;
      else                                           exp_next = m_pc + 32'd4;
      check("next_pc", 64'(next_pc), 64'(exp_next));
      check("query_pc", 64'(query_pc), 64'(exp_next));
      if (redir) begin
         m_ras.delete();
         if (m_uk == KCALL) ras_push(m_ua + 32'd4);
         if (m_cnt < 3) m_cnt++;
      end else if (fire && hit) begin
         if (kd == KCALL) ras_push(m_pc + 32'd4);
         else if (kd == KRET && m_ras.size() > 0) void'(m_ras.pop_back());
      end
      m_pc = exp_next; m_valid = 1'b1;
      m_uv = uv; m_um = um; m_uk = uk; m_ua = ua; m_ut = ut;
      @(posedge clk); #1;
      check_state("step");
   endtask

   task automatic seq(input logic rdy);
      step(rdy, 1'b0, 1'b0, KCOND, 32'h0, 1'b0, 1'b0, KCOND, 32'h0, 32'h0);
   endtask

   task automatic hit_step(input logic [1:0] kd, input logic [31:0] tgt);
      step(1'b1, 1'b1, 1'b1, kd, tgt, 1'b0, 1'b0, KCOND, 32'h0, 32'h0);
   endtask

   task automatic jump(input logic [31:0] tgt);
      step(1'b1, 1'b0, 1'b0, KCOND, 32'h0, 1'b1, 1'b1, KCOND, 32'h0, tgt);
      seq(1'b1);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check("rst.pc", 64'(pc), 64'(RV));
      check("rst.valid", 64'(fetch_valid), 64'h0);
      check("rst.rcnt", 64'(redirect_count), 64'h0);
      @(posedge clk); #1;
      check_state("rst_hold");
      rst = 1'b0;
   endtask

   int sat_exp[5] = '{1, 2, 3, 3, 3};
   int saved_cnt;

   initial begin
      model_reset();
      @(posedge clk); #1;
      apply_reset();
      seq(1'b1);
      seq(1'b1);
      seq(1'b1);

      // Mid-run reset and sequential fetch.
      @(posedge clk); #1;
      apply_reset();
      seq(1'b1);
      check("seq.first", 64'(pc), 64'h100);
      check("seq.valid", 64'(fetch_valid), 64'h1);
      seq(1'b1);
      check("seq.104", 64'(pc), 64'h104);
      seq(1'b1);
      check("seq.108", 64'(pc), 64'h108);

      // Stall, then mispredict arriving during the stall.
      jump(32'h200);
      saved_cnt = m_cnt;
      for (int i = 0; i < 3; i++) begin
         seq(1'b0);
         check("stall.pc", 64'(pc), 64'h200);
         check("stall.rcnt", 64'(redirect_count), 64'(saved_cnt));
      end
      step(1'b0, 1'b0, 1'b0, KCOND, 32'h0, 1'b1, 1'b1, KJUMP, 32'h200, 32'h800);
      check("stall.upd_edge1", 64'(pc), 64'h200);
      seq(1'b0);
      check("stall.redirect", 64'(pc), 64'h800);

      // Call / return.
      jump(32'h300);
      hit_step(KCALL, 32'h1000);
      check("call.pc", 64'(pc), 64'h1000);
      for (int i = 0; i < 4; i++) seq(1'b1);
      check("call.at_ret", 64'(pc), 64'h1010);
      hit_step(KRET, 32'hDEAD);
      check("ret.pc", 64'(pc), 64'h304);
      check("ret.rasn", 64'(dut.u_ras.count), 64'h0);

      // Overflow: nine nested calls into an eight-entry RAS.
      jump(32'h0);
      for (int i = 0; i < 9; i++) hit_step(KCALL, 32'((i + 1) * 16));
      check("ovf.rasn", 64'(dut.u_ras.count), 64'd8);
      for (int j = 0; j < 8; j++) begin
         hit_step(KRET, 32'hDEAD);
         check("ovf.ret", 64'(pc), 64'(32'h84 - 32'(j * 16)));
      end
      hit_step(KRET, 32'hBEEF0);
      check("ovf.empty_ret", 64'(pc), 64'hBEEF0);

      // Redirect repair with a resolved CALL.
      jump(32'h2000);
      hit_step(KCALL, 32'h3000);
      hit_step(KCALL, 32'h4000);
      hit_step(KCALL, 32'h5000);
      step(1'b1, 1'b0, 1'b0, KCOND, 32'h0, 1'b1, 1'b1, KCALL, 32'h500, 32'h900);
      seq(1'b1);
      check("repair.pc", 64'(pc), 64'h900);
      check("repair.rasn", 64'(dut.u_ras.count), 64'd1);
      hit_step(KRET, 32'hDEAD);
      check("repair.ret", 64'(pc), 64'h504);

      // Counter saturation with back-to-back redirects.
      @(posedge clk); #1;
      apply_reset();
      seq(1'b1);
      for (int k = 0; k < 6; k++) begin
         if (k < 5) step(1'b1, 1'b0, 1'b0, KCOND, 32'h0, 1'b1, 1'b1, KCOND, 32'h0,
                         32'(32'h40 * (k + 1)));
         else seq(1'b1);
         if (k >= 1) check("sat.rcnt", 64'(redirect_count), 64'(sat_exp[k-1]));
      end
      check("sat.last_pc", 64'(pc), 64'h140);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              {22'h0, 8'($urandom_range(0, 255)), 2'b00},
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), {20'h0, 10'($urandom), 2'b00},
              {20'h0, 10'($urandom), 2'b00});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_ras.md
Name: fetch_ras

Overview:
- Next-generation fetch PC generator. Selects next_pc each cycle from four sources: writeback redirect, return-address-stack (RAS) prediction, BTB/BPU prediction, or sequential pc+4.
- Parametrised address width, RAS depth and reset vector.
- Adds a fetch_valid/fetch_ready stall handshake toward decode and a redirect performance counter.
- BTB/BPU arrays stay external: they are queried with next_pc, and their registered result refers to pc.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, pc value after reset.
- RAS_DEPTH, 8, number of RAS entries; power of two, ≥2.
- CNT_W, 32, width of the redirect counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- upd_valid  in  1  writeback branch resolution valid.
- upd_taken  in  1  branch resolved taken.
- upd_mispredicted  in  1  fetch prediction was wrong.
- upd_kind  in  2  branch kind: 0 COND, 1 JUMP, 2 CALL, 3 RET.
- upd_addr  in  XLEN  branch pc.
- upd_target  in  XLEN  correct next pc.
- pred_hit  in  1  BTB hit for current pc.
- pred_taken  in  1  BPU taken, or no BPU entry (treated as taken).
- pred_kind  in  2  BTB-recorded kind for current pc.
- pred_target  in  XLEN  BTB target for current pc.
- fetch_ready  in  1  decode accepts pc this cycle.
- query_pc  out  XLEN  equals next_pc; drives the BTB/BPU read.
- pc  out  XLEN  current fetch pc.
- next_pc  out  XLEN  pc for the next cycle (combinational).
- fetch_valid  out  1  pc is a valid fetch.
- redirect_count  out  CNT_W  number of redirects taken, saturating.

Behaviour:
- Reset (async) values:
  - pc = RESET_VECTOR; fetch_valid = 0; redirect_count = 0.
  - All upd_* flops = 0.
  - RAS pointer = 0, RAS count = 0; RAS entry contents are don't-care.
- fetch_valid becomes 1 on the first clock edge after rst deasserts, then stays 1.
- Update path: all upd_* inputs are registered (upd_*_q), giving one cycle of latency. redirect = upd_valid_q & upd_mispredicted_q.
- fire = fetch_valid & fetch_ready.
- next_pc priority, highest first:
  1. redirect -> upd_target_q. Overrides the stall; the pc+4 term is ignored.
  2. !fire -> pc (hold).
  3. pred_hit & pred_kind==RET & ras_count>0 -> RAS top.
  4. pred_hit & (pred_kind!=COND | pred_taken) -> pred_target. This includes RET when the RAS is empty.
  5. Otherwise -> pc+4, modulo 2^XLEN, wrapping silently.
- pc <= next_pc every cycle.
- RAS speculative operations, only on fire & !redirect:
  - pred_hit & pred_kind==CALL: push pc+4.
  - pred_hit & pred_kind==RET & count>0: pop.
  - RET with count==0: no-op.
- RAS full: a push overwrites the oldest entry (circular). count saturates at RAS_DEPTH, so only the newest RAS_DEPTH returns are predicted.
- RAS repair on redirect:
  - count and pointer are cleared.
  - If upd_kind_q==CALL, upd_addr_q+4 is then pushed in the same cycle, leaving count=1.
  - No speculative op happens in that cycle.
- redirect_count increments on every redirect cycle and saturates at all-ones.
- Back-to-back redirects are each honoured; the last one wins pc.
- upd_valid_q with !upd_mispredicted_q: no pc or RAS effect.

Decomposition:
- Package fetch_pkg:
  - typedef enum br_kind_e {BR_COND, BR_JUMP, BR_CALL, BR_RET}.
  - Constant INSN_BYTES=4.
- Sub-module ras_stack, parameters DEPTH and XLEN:
  - Inputs: push, push_data, pop, clear.
  - Outputs: top, count.
  - clear has priority. clear+push yields count=1.
  - push+pop in the same cycle (unused here) replaces the top entry.

Test Plan:
- Reset and sequential fetch:
  - Assert rst mid-run with RESET_VECTOR=0x100 -> pc=0x100 immediately and fetch_valid=0.
  - Release rst with fetch_ready=1 and no hits -> fetch_valid=1 after the first edge, then pc 0x104, 0x108 on successive cycles.
- Stall:
  - Hold fetch_ready=0 at pc=0x200 for 3 cycles -> pc stays 0x200 and redirect_count is unchanged.
  - Pulse a mispredict during the stall with target 0x800 -> pc=0x800 two edges after the upd pulse.
- Call/return:
  - Hit CALL at 0x300 with target 0x1000 -> pc=0x1000.
  - Later hit RET at 0x1010 with pred_target 0xDEAD -> pc=0x304 and RAS count returns to 0.
- Overflow, RAS_DEPTH=8:
  - 9 nested calls from 0x0,0x10..0x80 -> count=8.
  - 8 returns yield 0x84,0x74..0x14.
  - A 9th RET uses pred_target.
- Redirect repair:
  - Fill 3 RAS entries, then apply upd mispredict with kind CALL, addr 0x500, target 0x900 -> pc=0x900 and count=1.
  - A following RET hit -> pc=0x504.
- Counter saturation with CNT_W=2:
  - 5 redirects -> redirect_count sequence 1,2,3,3,3.
